// File: rtl/wb_snoop_responder_pkg.sv
// Shared types and geometry constants for the dcache snoop responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snoop_pkg;

  // Default geometry: 32-bit addresses, 32-byte lines, 512 direct-mapped sets.
  localparam int TAG_W  = 18;
  localparam int SET_W  = 9;
  localparam int WORD_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_INV    = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  // Tag width left over once set index and line offset are removed from an address.
  function automatic int tag_width(input int dw, input int set_w, input int block_w);
    return dw - set_w - block_w;
  endfunction

  // Word offset width within a line of 2**block_w bytes (32-bit words).
  function automatic int word_width(input int block_w);
    return block_w - 2;
  endfunction

endpackage

// File: rtl/wb_snoop_responder_if.sv
// Snoop bus and dcache tag/data port bundle seen by the snoop responder.
// Latency: n/a (wires only).
// Backpressure: cache grant stalls the responder; responder drops on a full pending slot.
interface wb_snoop_responder_if
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH                = 32,
  parameter int OPTION_DCACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_DCACHE_SET_WIDTH   = 9
);
  localparam int TW = tag_width(DATA_WIDTH, OPTION_DCACHE_SET_WIDTH, OPTION_DCACHE_BLOCK_WIDTH);
  localparam int WW = word_width(OPTION_DCACHE_BLOCK_WIDTH);

  logic [DATA_WIDTH-1:0]              snoop_adr_i;
  logic                               snoop_req_i;
  logic                               snoop_ack_o;
  logic                               snoop_hit_o;
  logic [DATA_WIDTH-1:0]              snoop_dat_o;
  logic                               overflow_o;
  logic                               cp_req_o;
  logic                               cp_gnt_i;
  logic [OPTION_DCACHE_SET_WIDTH-1:0] cp_set_o;
  logic [WW-1:0]                      cp_word_o;
  logic                               cp_we_o;
  logic [TW-1:0]                      cp_tag_i;
  logic                               cp_valid_i;
  logic [DATA_WIDTH-1:0]              cp_dat_i;

  // Responder side.
  modport slave (
    input  snoop_adr_i, snoop_req_i, cp_gnt_i, cp_tag_i, cp_valid_i, cp_dat_i,
    output snoop_ack_o, snoop_hit_o, snoop_dat_o, overflow_o,
    output cp_req_o, cp_set_o, cp_word_o, cp_we_o
  );

  // Arbiter and cache side.
  modport master (
    output snoop_adr_i, snoop_req_i, cp_gnt_i, cp_tag_i, cp_valid_i, cp_dat_i,
    input  snoop_ack_o, snoop_hit_o, snoop_dat_o, overflow_o,
    input  cp_req_o, cp_set_o, cp_word_o, cp_we_o
  );

endinterface

// File: rtl/wb_snoop_responder.sv
// Looks up each snooped write address in the local dcache and invalidates the line on a hit.
// Latency: ack 3 cycles after the strobe on a miss, 4 on a hit, plus any cycles waiting for grant.
// Backpressure: one snoop in service plus one pending; a further strobe is dropped and flagged on overflow_o.
module wb_snoop_responder
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH                = 32,
  parameter int OPTION_DCACHE_BLOCK_WIDTH = 5,
  parameter int OPTION_DCACHE_SET_WIDTH   = 9
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_n_i,
  wb_snoop_responder_if.slave bus
);
  localparam int BW = OPTION_DCACHE_BLOCK_WIDTH;
  localparam int SW = OPTION_DCACHE_SET_WIDTH;

  state_t                state;
  logic [DATA_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] pend_adr;
  logic                  pend_vld;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic                  ack_r;
  logic                  hit_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ovf_r;
  logic                  req_r;
  logic                  we_r;

  logic                  lookup_hit;
  logic                  busy;
  logic                  unused_adr_bits;

  // Byte-offset bits never address the cache; fold them away explicitly.
  assign unused_adr_bits = ^adr_q[1:0];

  assign lookup_hit = bus.cp_valid_i && (bus.cp_tag_i == adr_q[DATA_WIDTH-1:SW+BW]);
  assign busy       = (state == ST_REQ) || (state == ST_LOOKUP) || (state == ST_INV);

  assign bus.cp_set_o    = adr_q[SW+BW-1:BW];
  assign bus.cp_word_o   = adr_q[BW-1:2];
  assign bus.cp_req_o    = req_r;
  assign bus.cp_we_o     = we_r;
  assign bus.snoop_ack_o = ack_r;
  assign bus.snoop_hit_o = hit_r;
  assign bus.snoop_dat_o = dat_r;
  assign bus.overflow_o  = ovf_r;

  // Snoop FSM, pending slot and registered outputs; outputs are set for the state being entered.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= ST_IDLE;
      adr_q    <= '0;
      pend_adr <= '0;
      pend_vld <= 1'b0;
      hit_q    <= 1'b0;
      dat_q    <= '0;
      ack_r    <= 1'b0;
      hit_r    <= 1'b0;
      dat_r    <= '0;
      ovf_r    <= 1'b0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      hit_r <= 1'b0;
      dat_r <= '0;
      ovf_r <= 1'b0;
      req_r <= 1'b0;
      we_r  <= 1'b0;

      // While a snoop is in flight, park one more strobe; anything beyond that is lost.
      if (bus.snoop_req_i && busy) begin
        if (!pend_vld) begin
          pend_vld <= 1'b1;
          pend_adr <= bus.snoop_adr_i;
        end else begin
          ovf_r <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (bus.snoop_req_i) begin
            adr_q <= bus.snoop_adr_i;
            state <= ST_REQ;
            req_r <= 1'b1;
          end
        end
        ST_REQ: begin
          req_r <= 1'b1;
          if (bus.cp_gnt_i) begin
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          hit_q <= lookup_hit;
          dat_q <= bus.cp_dat_i;
          if (lookup_hit) begin
            state <= ST_INV;
            req_r <= 1'b1;
            we_r  <= 1'b1;
          end else begin
            state <= ST_ACK;
            ack_r <= 1'b1;
          end
        end
        ST_INV: begin
          state <= ST_ACK;
          ack_r <= 1'b1;
          hit_r <= hit_q;
          dat_r <= hit_q ? dat_q : '0;
        end
        ST_ACK: begin
          // The ack cycle frees the pending slot, so a strobe here is never dropped.
          if (pend_vld) begin
            adr_q    <= pend_adr;
            state    <= ST_REQ;
            req_r    <= 1'b1;
            pend_vld <= bus.snoop_req_i;
            if (bus.snoop_req_i) begin
              pend_adr <= bus.snoop_adr_i;
            end
          end else if (bus.snoop_req_i) begin
            adr_q <= bus.snoop_adr_i;
            state <= ST_REQ;
            req_r <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Bench for the snoop responder: directed latency/overflow/reset scenarios plus randomized snoops.
// The dcache is a behavioural array; a separate reference copy of valid bits predicts every ack.
// Grant is tied, stalled, or randomized while honouring the hold-while-requesting rule.
module tb_wb_snoop_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_snoop_responder_if #(
    .DATA_WIDTH(32), .OPTION_DCACHE_BLOCK_WIDTH(5), .OPTION_DCACHE_SET_WIDTH(9)
  ) bus ();

  wb_snoop_responder #(
    .DATA_WIDTH(32), .OPTION_DCACHE_BLOCK_WIDTH(5), .OPTION_DCACHE_SET_WIDTH(9)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural dcache presented to the DUT.
  logic [17:0] c_tag [512];
  logic        c_vld [512];
  logic [31:0] c_dat [512][8];
  // Reference valid bits, updated only from the specification's hit rule.
  logic        r_vld [512];
  logic        gnt_rand = 1'b0;

  assign bus.cp_tag_i   = c_tag[bus.cp_set_o];
  assign bus.cp_valid_i = c_vld[bus.cp_set_o];
  assign bus.cp_dat_i   = c_dat[bus.cp_set_o][bus.cp_word_o];

  // Cache applies the invalidate write.
  always @(posedge clk) begin
    if (rst_n && bus.cp_we_o) c_vld[bus.cp_set_o] = 1'b0;
  end

  // Random grant: once granted, hold while the port is still requested.
  always @(negedge clk) begin
    if (gnt_rand) begin
      if (!(bus.cp_req_o && bus.cp_gnt_i)) bus.cp_gnt_i = ($urandom_range(0, 2) == 0);
    end
  end

  // Grant must not drop while the responder holds the port after being granted.
  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.cp_req_o && bus.cp_gnt_i) |=> (bus.cp_gnt_i || !bus.cp_req_o))
    else $error("grant withdrawn while cache port held");

  // Drives strobes per cycle (bit c of strobes at cycle c) and records what the DUT does.
  task automatic run_seq(input logic [15:0] strobes, input int stall, input logic [31:0] adr,
                         output int acks, output int a0, output int a1, output int a2,
                         output int ovf_n, output int ovf_c, output int we_n, output int we_c,
                         output logic hit, output logic [31:0] dat,
                         output logic [8:0] set1, output logic [2:0] word1, output logic req5);
    acks = 0; a0 = -1; a1 = -1; a2 = -1; ovf_n = 0; ovf_c = -1; we_n = 0; we_c = -1;
    hit = 1'b0; dat = '0; set1 = '0; word1 = '0; req5 = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        if (bus.snoop_ack_o) begin
          if (acks == 0) a0 = c;
          else if (acks == 1) a1 = c;
          else if (acks == 2) a2 = c;
          acks++;
          hit = bus.snoop_hit_o;
          dat = bus.snoop_dat_o;
        end
        if (bus.overflow_o) begin
          if (ovf_n == 0) ovf_c = c;
          ovf_n++;
        end
        if (bus.cp_we_o) begin
          if (we_n == 0) we_c = c;
          we_n++;
        end
        if (c == 1) begin
          set1  = bus.cp_set_o;
          word1 = bus.cp_word_o;
        end
        if (c == 5) req5 = bus.cp_req_o;
      end
      bus.snoop_req_i = (c < 16) ? strobes[c] : 1'b0;
      bus.snoop_adr_i = adr + (32'(c) << 14);
      bus.cp_gnt_i    = (c > stall);
      @(negedge clk);
    end
    bus.snoop_req_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bus.snoop_ack_o, bus.snoop_hit_o, bus.overflow_o, bus.cp_req_o, bus.cp_we_o, bus.snoop_dat_o} !== 37'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
        {bus.snoop_ack_o, bus.snoop_hit_o, bus.overflow_o, bus.cp_req_o, bus.cp_we_o, bus.snoop_dat_o});
    end
    n_checks++;
    if (bus.cp_set_o !== 9'd0 || bus.cp_word_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_adr: got set %h word %h want 0", bus.cp_set_o, bus.cp_word_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_miss();
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    run_seq(16'h0001, 0, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (s1 !== 9'h091) begin n_fail++; $display("FAIL miss_set: got %h want 091", s1); end
    n_checks++; if (w1 !== 3'd5) begin n_fail++; $display("FAIL miss_word: got %0d want 5", w1); end
    n_checks++; if (a0 != 3 || acks != 1) begin n_fail++; $display("FAIL miss_ack: cycle %0d count %0d want 3/1", a0, acks); end
    n_checks++; if (hit !== 1'b0 || dat !== 32'd0) begin n_fail++; $display("FAIL miss_resp: hit %b dat %h want 0/0", hit, dat); end
    n_checks++; if (we_n != 0) begin n_fail++; $display("FAIL miss_we: got %0d writes want 0", we_n); end
  endtask

  task automatic test_hit();
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    for (int w = 0; w < 8; w++) c_dat[9'h091][w] = 32'h1111_0000 + 32'(w);
    c_vld[9'h091] = 1'b1; c_tag[9'h091] = 18'd0; c_dat[9'h091][5] = 32'hDEAD_BEEF;
    run_seq(16'h0001, 0, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (we_c != 3 || we_n != 1) begin n_fail++; $display("FAIL hit_we: cycle %0d count %0d want 3/1", we_c, we_n); end
    n_checks++; if (a0 != 4 || acks != 1) begin n_fail++; $display("FAIL hit_ack: cycle %0d count %0d want 4/1", a0, acks); end
    n_checks++; if (hit !== 1'b1 || dat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_resp: hit %b dat %h want 1/deadbeef", hit, dat); end
    n_checks++; if (c_vld[9'h091] !== 1'b0) begin n_fail++; $display("FAIL hit_invalidate: valid %b want 0", c_vld[9'h091]); end
  endtask

  task automatic test_grant_stall();
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    run_seq(16'h0001, 5, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (req5 !== 1'b1) begin n_fail++; $display("FAIL stall_req_held: got %b want 1", req5); end
    n_checks++; if (a0 != 8 || acks != 1) begin n_fail++; $display("FAIL stall_ack: cycle %0d count %0d want 8/1", a0, acks); end
  endtask

  task automatic test_back_to_back();
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    run_seq(16'h0007, 3, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (acks != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    n_checks++; if (ovf_n != 1 || ovf_c != 3) begin n_fail++; $display("FAIL b2b_overflow: count %0d cycle %0d want 1/3", ovf_n, ovf_c); end
    n_checks++; if (a0 != 6 || a1 != 9) begin n_fail++; $display("FAIL b2b_ack_cycles: got %0d,%0d want 6,9", a0, a1); end
  endtask

  task automatic test_ack_refill();
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    // Strobe in the ack cycle while the pending slot is full: slot is recycled, nothing lost.
    run_seq(16'h000B, 0, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (acks != 3 || ovf_n != 0) begin n_fail++; $display("FAIL refill_full: acks %0d ovf %0d want 3/0", acks, ovf_n); end
    n_checks++; if (a1 != 6 || a2 != 9) begin n_fail++; $display("FAIL refill_cycles: got %0d,%0d want 6,9", a1, a2); end
    // Strobe in the ack cycle with the pending slot empty.
    run_seq(16'h0009, 0, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (acks != 2 || ovf_n != 0 || a1 != 6) begin
      n_fail++; $display("FAIL refill_empty: acks %0d ovf %0d second %0d want 2/0/6", acks, ovf_n, a1);
    end
  endtask

  task automatic test_reset_inv();
    int bad = 0;
    int acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c; logic hit, req5; logic [31:0] dat;
    logic [8:0] s1; logic [2:0] w1;
    c_vld[9'h091] = 1'b1; c_tag[9'h091] = 18'd0;
    bus.cp_gnt_i = 1'b1;
    @(negedge clk);
    bus.snoop_req_i = 1'b1; bus.snoop_adr_i = 32'h0000_1234;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.snoop_req_i = 1'b0;
    end
    n_checks++; if (bus.cp_we_o !== 1'b1) begin n_fail++; $display("FAIL rstinv_in_inv: we %b want 1", bus.cp_we_o); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.snoop_ack_o, bus.cp_we_o, bus.cp_req_o, bus.overflow_o, bus.snoop_hit_o, bus.snoop_dat_o} !== 37'd0) begin
      n_fail++; $display("FAIL rstinv_outputs: got %h want 0",
        {bus.snoop_ack_o, bus.cp_we_o, bus.cp_req_o, bus.overflow_o, bus.snoop_hit_o, bus.snoop_dat_o});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.snoop_ack_o || bus.cp_we_o) bad++;
    end
    n_checks++; if (bad != 0 || c_vld[9'h091] !== 1'b1) begin
      n_fail++; $display("FAIL rstinv_abandon: stray cycles %0d valid %b want 0/1", bad, c_vld[9'h091]);
    end
    run_seq(16'h0001, 0, 32'h0000_1234, acks, a0, a1, a2, ovf_n, ovf_c, we_n, we_c, hit, dat, s1, w1, req5);
    n_checks++; if (a0 != 4 || hit !== 1'b1 || dat !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rstinv_next: ack %0d hit %b dat %h want 4/1/deadbeef", a0, hit, dat);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] a;
    logic [8:0]  st;
    logic        exp_hit;
    logic [31:0] exp_dat;
    int issued = 0;
    int outstanding = 0;
    for (int s = 0; s < 4; s++) begin
      c_vld[s] = 1'($urandom_range(0, 1));
      c_tag[s] = 18'($urandom_range(0, 1));
      r_vld[s] = c_vld[s];
      for (int w = 0; w < 8; w++) c_dat[s][w] = $urandom;
    end
    gnt_rand = 1'b1;
    for (int cyc = 0; cyc < 3000 && (issued < 40 || outstanding > 0); cyc++) begin
      @(negedge clk);
      if (bus.snoop_ack_o) begin
        outstanding--;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_ack: ack with %0d expected outstanding", exp_q.size());
        end else begin
          a  = exp_q.pop_front();
          st = a[13:5];
          exp_hit = r_vld[st] && (c_tag[st] == a[31:14]);
          exp_dat = exp_hit ? c_dat[st][a[4:2]] : 32'd0;
          if (exp_hit) r_vld[st] = 1'b0;
          if (bus.snoop_hit_o !== exp_hit || bus.snoop_dat_o !== exp_dat) begin
            n_fail++; $display("FAIL rand_resp adr %h: hit %b dat %h want %b/%h",
                               a, bus.snoop_hit_o, bus.snoop_dat_o, exp_hit, exp_dat);
          end
        end
      end
      if (bus.overflow_o) begin
        n_checks++; n_fail++; $display("FAIL rand_overflow: overflow 1 want 0");
      end
      if (issued < 40 && outstanding < 2 && $urandom_range(0, 1) == 1) begin
        a = {17'd0, 1'($urandom_range(0, 1)), 7'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
        bus.snoop_adr_i = a;
        bus.snoop_req_i = 1'b1;
        exp_q.push_back(a);
        issued++;
        outstanding++;
      end else begin
        bus.snoop_req_i = 1'b0;
      end
    end
    bus.snoop_req_i = 1'b0;
    gnt_rand = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout: %0d acks missing want 0", exp_q.size()); end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (c_vld[s] !== r_vld[s]) begin n_fail++; $display("FAIL rand_valid set %0d: got %b want %b", s, c_vld[s], r_vld[s]); end
    end
  endtask

  initial begin
    bus.snoop_req_i = 1'b0;
    bus.snoop_adr_i = '0;
    bus.cp_gnt_i    = 1'b0;
    for (int s = 0; s < 512; s++) begin
      c_vld[s] = 1'b0; r_vld[s] = 1'b0; c_tag[s] = '0;
      for (int w = 0; w < 8; w++) c_dat[s][w] = '0;
    end
    test_reset();
    test_miss();
    test_hit();
    test_grant_stall();
    test_back_to_back();
    test_ack_refill();
    test_reset_inv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_snoop_responder.md
WB_SNOOP_RESPONDER -- requirements
Module: wb_snoop_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning snoop address/data width.
REQ-002 SHALL have parameter OPTION_DCACHE_BLOCK_WIDTH, default 5, meaning log2 line bytes.
REQ-003 SHALL have parameter OPTION_DCACHE_SET_WIDTH, default 9, meaning log2 sets (direct-mapped); TAG_W = DATA_WIDTH-SET-BLOCK = 18.
REQ-004 SHALL have port wb_clk_i, input, 1, the only clock, rising edge.
REQ-005 SHALL have port wb_rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port snoop_adr_i, input, DATA_WIDTH, snooped write address, valid with snoop_req_i.
REQ-007 SHALL have port snoop_req_i, input, 1, one-cycle snoop request strobe from the bus arbiter.
REQ-008 SHALL have port snoop_ack_o, output, 1, one-cycle response strobe.
REQ-009 SHALL have port snoop_hit_o, output, 1, line present in this core's dcache; valid with snoop_ack_o.
REQ-010 SHALL have port snoop_dat_o, output, DATA_WIDTH, cached word at snooped address on hit, else 0.
REQ-011 SHALL have port overflow_o, output, 1, one-cycle pulse when a request is dropped.
REQ-012 SHALL have port cp_req_o, input-side request, output, 1, requests the dcache tag/data port.
REQ-013 SHALL have port cp_gnt_i, input, 1, port granted; held by cache while cp_req_o high.
REQ-014 SHALL have ports cp_set_o (output, SET_W) and cp_word_o (output, BLOCK_W-2), lookup index and word offset.
REQ-015 SHALL have port cp_we_o, output, 1, invalidate write (valid bit cleared) at cp_set_o.
REQ-016 SHALL have ports cp_tag_i (TAG_W), cp_valid_i (1), cp_dat_i (DATA_WIDTH), inputs, read data one cycle after granted read.

Function
REQ-017 SHALL implement FSM IDLE, REQ, LOOKUP, INV, ACK.
REQ-018 IDLE: snoop_req_i=1 latches snoop_adr_i into adr_q -> REQ.
REQ-019 REQ: cp_req_o=1, cp_set_o=adr_q[SET+BLOCK-1:BLOCK], cp_word_o=adr_q[BLOCK-1:2]; cp_gnt_i=1 -> LOOKUP, else stay.
REQ-020 LOOKUP: cp_req_o=1; hit = cp_valid_i & (cp_tag_i == adr_q[DW-1:SET+BLOCK]); register hit and cp_dat_i; hit -> INV, miss -> ACK.
REQ-021 INV: cp_req_o=1, cp_we_o=1 for exactly one cycle -> ACK.
REQ-022 ACK: snoop_ack_o=1, snoop_hit_o=hit_q, snoop_dat_o=hit_q?dat_q:0, for one cycle; pending entry valid -> REQ with pending address, else IDLE.
REQ-023 Latency with immediate grant: req at cycle 0 -> ack at cycle 3 (miss) or 4 (hit).
REQ-024 snoop_ack_o, snoop_hit_o, cp_we_o SHALL be 0 outside their states; snoop_dat_o 0 when not acking.
REQ-025 snoop_req_i outside IDLE SHALL be stored in a one-entry pending buffer (address).
REQ-026 snoop_req_i while pending buffer full SHALL be dropped and overflow_o pulsed next cycle.
REQ-027 In ACK, simultaneous snoop_req_i and pending valid: pending entry consumed, new request captured into the freed entry.
REQ-028 In ACK with pending empty and snoop_req_i=1: request goes to pending and is served next (no drop).
REQ-029 cp_gnt_i deasserting in LOOKUP or INV is a protocol violation; behaviour unspecified; assertion required in bench.

Reset
REQ-030 wb_rst_n_i=0 SHALL asynchronously force IDLE, clear pending, adr_q, hit_q, dat_q, all outputs 0.
REQ-031 Reset mid-operation SHALL abandon the snoop with no ack and no cp_we_o.
REQ-032 Reset release SHALL be synchronized externally; first request accepted on first edge after release.

Structure
REQ-033 snoop_pkg SHALL hold the FSM state enum and TAG_W/SET_W/word-offset width constants.
REQ-034 No sub-module; pending buffer inline (single register + valid).

Verification
REQ-035 Miss: adr 0x0000_1234, cp_gnt_i tied 1, cp_valid_i=0 -> cp_set_o=0x091, cp_word_o=5, ack cycle 3, hit=0, dat=0, no cp_we_o.
REQ-036 Hit: same adr, cp_valid_i=1, cp_tag_i=0, cp_dat_i=0xDEAD_BEEF -> cp_we_o at cycle 3, ack cycle 4, hit=1, dat=0xDEAD_BEEF.
REQ-037 Grant stall: cp_gnt_i low 5 cycles -> cp_req_o held, ack 5 cycles later than REQ-035.
REQ-038 Back-to-back: three strobes at cycles 0,1,2 with grant stalled -> 2nd pending, 3rd dropped, overflow_o pulse at cycle 3, exactly two acks.
REQ-039 Reset in INV (wb_rst_n_i low one cycle) -> outputs 0 immediately, no ack, next request served normally.
